// File: rtl/nn_pkg.sv
// Shared types and default widths for the neuron weight path.
package nn_pkg;

  localparam int NN_DATA_WIDTH = 8;
  localparam int NN_ADDR_WIDTH = 8;
  localparam int NN_FIFO_DEPTH = 4;

  typedef logic [NN_DATA_WIDTH-1:0] weight_t;
  typedef logic [NN_ADDR_WIDTH-1:0] waddr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/weight_fetch_fifo.sv
// Show-ahead return-data buffer between the weight RAM and the MAC stream.
// The head entry is visible on rdata whenever the buffer is non-empty.
module weight_fetch_fifo
  import nn_pkg::*;
#(
  parameter int WIDTH = NN_DATA_WIDTH,
  parameter int DEPTH = NN_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW:0]      level_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty     = (level_r == '0);
  assign full      = (level_r == (PW+1)'(DEPTH));
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign rdata     = mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + (PW+1)'(1);
        2'b01:   level_r <= level_r - (PW+1)'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Weight RAM read initiator: credit-limited burst fetch into a show-ahead buffer.
// Optional macro WEIGHT_FETCH_CHECKSUM_EN adds a running checksum of delivered weights.
module weight_fetch_ctrl
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH = NN_DATA_WIDTH,
  parameter int ADDR_WIDTH = NN_ADDR_WIDTH,
  parameter int FIFO_DEPTH = NN_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_address_valid,
  input  logic [DATA_WIDTH-1:0] ram_read_data,
  input  logic                  ram_read_data_valid,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic                  w_last
`ifdef WEIGHT_FETCH_CHECKSUM_EN
  ,
  output logic [15:0]           checksum
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [CW-1:0]       CRD_ONE  = CW'(1);
  localparam logic [CW-1:0]       CRD_FULL = CW'(FIFO_DEPTH);

  fetch_state_e          state_r;
  fetch_state_e          state_s;
  logic [ADDR_WIDTH-1:0] base_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [ADDR_WIDTH-1:0] issue_addr_s;
  logic [ADDR_WIDTH:0]   count_r;
  logic [ADDR_WIDTH:0]   issued_r;
  logic [ADDR_WIDTH:0]   issued_nxt_s;
  logic [ADDR_WIDTH:0]   popped_r;
  logic [CW-1:0]         credits_r;
  logic [CW-1:0]         outstanding_r;
  logic                  addr_valid_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  start_ok_s;
  logic                  issue_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  last_beat_s;
  logic                  fifo_empty_s;
  logic                  fifo_full_s;
  logic [DATA_WIDTH-1:0] fifo_rdata_s;

  assign start_ok_s  = (state_r == IDLE) && start;
  // A return is only accepted against an outstanding request; strays are dropped.
  assign push_s      = ram_read_data_valid && (outstanding_r != '0) && !fifo_full_s;
  assign pop_s       = !fifo_empty_s && w_ready;
  assign last_beat_s = (popped_r == (count_r - CNT_ONE));

  weight_fetch_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .wdata (ram_read_data),
    .pop   (pop_s),
    .rdata (fifo_rdata_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = (count == '0) ? DONE : FETCH;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        if (issued_nxt_s == count_r) begin
          state_s = DRAIN;
        end else begin
          state_s = FETCH;
        end
      end
      DRAIN: begin
        if (pop_s && last_beat_s) begin
          state_s = DONE;
        end else begin
          state_s = DRAIN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // FSM output decode: the issue decision is made one cycle ahead of the
  // registered address strobe, so credits are consumed at decision time.
  always_comb begin
    issue_s      = 1'b0;
    issue_addr_s = base_r + issued_r[ADDR_WIDTH-1:0];
    issued_nxt_s = issued_r;
    case (state_r)
      IDLE: begin
        if (start && (count != '0)) begin
          issue_s      = 1'b1;
          issue_addr_s = base_addr;
        end else begin
          issue_s = 1'b0;
        end
      end
      FETCH: begin
        if ((credits_r != '0) && (issued_r < count_r)) begin
          issue_s = 1'b1;
        end else begin
          issue_s = 1'b0;
        end
      end
      default: issue_s = 1'b0;
    endcase
    if (start_ok_s) begin
      issued_nxt_s = issue_s ? CNT_ONE : '0;
    end else if (issue_s) begin
      issued_nxt_s = issued_r + CNT_ONE;
    end else begin
      issued_nxt_s = issued_r;
    end
  end

  // Job parameters, issue/pop counters, credits and outstanding requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_r        <= '0;
      count_r       <= '0;
      issued_r      <= '0;
      popped_r      <= '0;
      credits_r     <= CRD_FULL;
      outstanding_r <= '0;
    end else begin
      if (start_ok_s) begin
        base_r   <= base_addr;
        count_r  <= count;
        popped_r <= '0;
      end else if (pop_s) begin
        popped_r <= popped_r + CNT_ONE;
      end
      issued_r <= issued_nxt_s;
      case ({issue_s, pop_s})
        2'b10:   credits_r <= credits_r - CRD_ONE;
        2'b01:   credits_r <= credits_r + CRD_ONE;
        default: credits_r <= credits_r;
      endcase
      case ({issue_s, push_s})
        2'b10:   outstanding_r <= outstanding_r + CRD_ONE;
        2'b01:   outstanding_r <= outstanding_r - CRD_ONE;
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

  // Registered RAM request and job status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r       <= '0;
      addr_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      addr_valid_r <= issue_s;
      if (issue_s) begin
        addr_r <= issue_addr_s;
      end
      busy_r <= (state_s == FETCH) || (state_s == DRAIN);
      done_r <= (state_s == DONE);
    end
  end

  assign ram_address       = addr_r;
  assign ram_address_valid = addr_valid_r;
  assign busy              = busy_r;
  assign done              = done_r;
  assign w_valid           = !fifo_empty_s;
  assign w_data            = fifo_empty_s ? '0 : fifo_rdata_s;
  assign w_last            = !fifo_empty_s && last_beat_s;

`ifdef WEIGHT_FETCH_CHECKSUM_EN
  logic [15:0] checksum_r;

  // Running modulo-2^16 sum of delivered weights; holds between jobs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_r <= 16'h0000;
    end else if (start_ok_s) begin
      checksum_r <= 16'h0000;
    end else if (pop_s) begin
      checksum_r <= checksum_r + 16'(fifo_rdata_s);
    end
  end

  assign checksum = checksum_r;
`endif

endmodule

// File: doc/weight_fetch_ctrl.md
Name: weight_fetch_ctrl

Overview:
Initiator side of the weight RAM read interface. On a start command it issues a burst of sequential addresses with address_valid, and captures each returned read_data beat. It buffers the beats in a small FIFO and delivers them to the neuron MAC datapath on a valid/ready weight stream. Outstanding reads are credit-limited, so returned data can never overflow the buffer.

Parameters:
DATA_WIDTH, 8, weight word width; matches RAM read_data width
ADDR_WIDTH, 8, RAM address width; addresses wrap modulo 2^ADDR_WIDTH
FIFO_DEPTH, 4, return-data buffer entries (power of 2, >=2); also the credit limit

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle job request; accepted only in IDLE
base_addr  in  ADDR_WIDTH  first weight address, sampled on accepted start
count  in  ADDR_WIDTH+1  number of weights, 0..2^ADDR_WIDTH, sampled on accepted start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at job end
ram_address  out  ADDR_WIDTH  read address to weight RAM
ram_address_valid  out  1  read request strobe, one beat per cycle
ram_read_data  in  DATA_WIDTH  RAM return data
ram_read_data_valid  in  1  RAM return strobe
w_data  out  DATA_WIDTH  weight to MAC
w_valid  out  1  w_data valid
w_ready  in  1  MAC accepts weight
w_last  out  1  high with the final weight of the job

Behaviour:
- Reset: all outputs 0, FSM in IDLE, credits = FIFO_DEPTH, FIFO empty. Asserting reset mid-job aborts the job immediately; in-flight RAM returns after reset are ignored.
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - start with count>0 latches base_addr/count and goes to FETCH; busy goes high next cycle.
  - start with count=0 goes to DONE; no address is issued.
- FETCH: ram_address_valid=1 in any cycle where credits>0 and issued<count. ram_address = base_addr + issued, wrapping modulo 2^ADDR_WIDTH. Both outputs are registered. After the last issue, go to DRAIN.
- DRAIN: wait until the last weight is popped (w_valid & w_ready & w_last), then go to DONE.
- DONE: done=1 and busy=0 for one cycle, then go to IDLE.
- start outside IDLE is ignored, with no side effects.
- Credits:
  - decrement on each issue; increment on each pop.
  - simultaneous issue and pop leaves credits unchanged.
  - invariant: credits + outstanding + FIFO occupancy = FIFO_DEPTH.
- ram_read_data_valid writes ram_read_data into the FIFO the same cycle. A return with no outstanding request is dropped.
- The FIFO is show-ahead: w_valid=1 whenever the FIFO is non-empty. w_data and w_valid are held stable while w_ready=0.
- w_last=1 only on the beat whose pop index equals count-1.
- Latency with a 1-cycle RAM and w_ready=1:
  - start accepted in cycle 0 gives first ram_address_valid in cycle 1 and first w_valid in cycle 3.
  - sustained throughput is 1 weight/cycle.
- Counters are ADDR_WIDTH+1 bits, so count = 2^ADDR_WIDTH covers the full RAM.

Optional Feature:
Macro WEIGHT_FETCH_CHECKSUM_EN.
- Defined: adds output port checksum [15:0]. It is cleared on accepted start and adds the zero-extended w_data on every pop, wrapping modulo 2^16. It holds its value from DONE until the next accepted start. Reset value is 0.
- Undefined: no port and no logic.

Decomposition:
- Package nn_pkg holds:
  - DATA_WIDTH/ADDR_WIDTH defaults as localparams.
  - weight_t and waddr_t typedefs.
  - the fetch_state_e enum {IDLE, FETCH, DRAIN, DONE}.
- Sub-module weight_fetch_fifo: synchronous show-ahead FIFO with push/pop/empty/full and registered storage. The controller holds the FSM, address, issue and pop counters, and credits.

Test Plan:
- base_addr=0x10, count=4, w_ready=1, RAM returns data=addr -> addresses 0x10..0x13 on cycles 1-4; w_data 0x10..0x13 on cycles 3-6; w_last on 0x13; done one cycle after the last pop.
- count=8, FIFO_DEPTH=4, w_ready=0 -> exactly 4 address beats, then address_valid stays low. Raise w_ready -> remaining 4 issued, 8 weights delivered in order.
- base_addr=0xFE, count=4 -> addresses FE, FF, 00, 01; w_last on the 4th beat.
- count=0 -> done pulse in cycle 1, ram_address_valid never asserted, busy stays 0.
- start pulsed again mid-job -> ignored, same 4 beats. rst_n low after 2 beats -> all outputs 0, IDLE, late RAM returns dropped, FIFO empty.
- WEIGHT_FETCH_CHECKSUM_EN, data 0xFF x 4 -> checksum=0x03FC after done.
